// File: rtl/rle_pkg.sv
// Shared definitions for the logic analyzer RLE path.
// The word layout below is the same one the RLE encoder emits.
package rle_pkg;

  localparam int DW = 8;  // sample data width
  localparam int CW = 8;  // run-length count width

  // One encoded word: the run length is cnt+1, so cnt=0 means a single sample.
  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [DW-1:0] dat;
  } rle_word_t;

  // Decoder state: RUN means the holding register has a run to emit.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rle_dec.sv
// Run-length decoder: expands {count, data} words into count+1 samples.
// Optional macro RLE_DEC_CNT_EN enables the expanded-sample counter on
// sts_smp; without it sts_smp is tied to zero.
//
// Handshake semantics (both ports): a beat transfers on a rising clk edge
// where tvalid and tready are both 1. Once sto_tvalid is raised it stays
// high, with tdata/tkeep/tlast unchanged, until the beat transfers.
// sto_tvalid never depends on sto_tready. sti_tready may depend on
// sto_tready so that a finished run and the next word load in the same
// cycle with no bubble.
module rle_dec #(
  parameter int DW = rle_pkg::DW,
  parameter int CW = rle_pkg::CW,
  parameter int SW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctl_rst,
  input  logic             cfg_ena,
  input  logic [CW+DW-1:0] sti_tdata,
  input  logic             sti_tkeep,
  input  logic             sti_tlast,
  input  logic             sti_tvalid,
  output logic             sti_tready,
  output logic [DW-1:0]    sto_tdata,
  output logic             sto_tkeep,
  output logic             sto_tlast,
  output logic             sto_tvalid,
  input  logic             sto_tready,
  output logic [SW-1:0]    sts_smp
);

  import rle_pkg::*;

  state_t          state_q;
  state_t          state_d;
  logic [DW-1:0]   dat_q;
  logic            kep_q;
  logic            lst_q;
  logic [CW-1:0]   rem_q;
  logic            busy;
  logic            rem_zero;
  logic            load;
  logic            dec;
  logic            clr;

  assign clr      = rst | ctl_rst;
  assign busy     = (state_q == ST_RUN);
  assign rem_zero = (rem_q == '0);

  // Next state, input ready and holding-register controls.
  always_comb begin
    state_d    = state_q;
    sti_tready = 1'b0;
    load       = 1'b0;
    dec        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sti_tready = 1'b1;
        if (sti_tvalid) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sto_tready) begin
          if (!rem_zero) begin
            dec = 1'b1;
          end else begin
            // Last sample of the run leaves now; take the next word at once.
            sti_tready = 1'b1;
            if (sti_tvalid) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and holding register; either reset discards the run.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      kep_q   <= 1'b0;
      lst_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        dat_q <= sti_tdata[DW-1:0];
        kep_q <= sti_tkeep;
        lst_q <= sti_tlast;
        // Pass-through mode ignores the count: every word is one sample.
        rem_q <= cfg_ena ? sti_tdata[CW+DW-1:DW] : '0;
      end else if (dec) begin
        rem_q <= rem_q - CW'(1);
      end
    end
  end

  // Outputs come straight from the holding register, gated by busy.
  always_comb begin
    sto_tvalid = busy;
    sto_tdata  = busy ? dat_q : '0;
    sto_tkeep  = busy & kep_q;
    sto_tlast  = busy & lst_q & rem_zero;
  end

`ifdef RLE_DEC_CNT_EN
  logic [SW-1:0] smp_q;

  // Count every sample accepted downstream; wraps naturally.
  always_ff @(posedge clk) begin
    if (clr) begin
      smp_q <= '0;
    end else if (sto_tvalid && sto_tready) begin
      smp_q <= smp_q + SW'(1);
    end
  end

  assign sts_smp = smp_q;
`else
  assign sts_smp = '0;
`endif

endmodule

// File: tb/tb_rle_dec.sv
// Self-checking bench for rle_dec: directed steps followed by a random phase,
// all outputs compared against a queue of expected samples built from the
// words the bench handed to the decoder.
module tb_rle_dec;
  import rle_pkg::*;

  localparam int P_DW = 8;
  localparam int P_CW = 8;
  localparam int P_SW = 32;

  logic                 clk;
  logic                 rst;
  logic                 ctl_rst;
  logic                 cfg_ena;
  logic [P_CW+P_DW-1:0] sti_tdata;
  logic                 sti_tkeep;
  logic                 sti_tlast;
  logic                 sti_tvalid;
  logic                 sti_tready;
  logic [P_DW-1:0]      sto_tdata;
  logic                 sto_tkeep;
  logic                 sto_tlast;
  logic                 sto_tvalid;
  logic                 sto_tready;
  logic [P_SW-1:0]      sts_smp;

  rle_dec #(.DW(P_DW), .CW(P_CW), .SW(P_SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctl_rst    (ctl_rst),
    .cfg_ena    (cfg_ena),
    .sti_tdata  (sti_tdata),
    .sti_tkeep  (sti_tkeep),
    .sti_tlast  (sti_tlast),
    .sti_tvalid (sti_tvalid),
    .sti_tready (sti_tready),
    .sto_tdata  (sto_tdata),
    .sto_tkeep  (sto_tkeep),
    .sto_tlast  (sto_tlast),
    .sto_tvalid (sto_tvalid),
    .sto_tready (sto_tready),
    .sts_smp    (sts_smp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {tlast, tkeep, tdata}
  logic [P_DW+1:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int exp_pushed = 0;   // samples the model expects since the last reset
  int n_beats = 0;      // output handshakes seen
  int first_cyc = -1;
  int last_cyc = -1;
  bit rdy_rand = 0;
  bit rdy_pat[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  logic            held_v = 1'b0;
  logic [P_DW+1:0] held;

  // Output monitor: checks each accepted beat and stability while stalled.
  always @(negedge clk) begin
    if (sto_tvalid === 1'b1) begin
      if (held_v) chk("stall_stable", {sto_tlast, sto_tkeep, sto_tdata}, held);
      if (sto_tready) begin
        n_beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $error("FAIL extra_beat observed=%0h expected=none", sto_tdata);
        end else begin
          chk("beat", {sto_tlast, sto_tkeep, sto_tdata}, exp_q.pop_front());
        end
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held   = {sto_tlast, sto_tkeep, sto_tdata};
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one cycle; new inputs appear 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_pat.size() != 0) begin
      sto_tready = rdy_pat.pop_front();
    end else if (rdy_rand) begin
      sto_tready = ($urandom_range(0, 3) != 0);
      cfg_ena    = 1'($urandom_range(0, 1));
    end else begin
      sto_tready = 1'b1;
    end
  endtask

  // Offer one word until accepted, then add its expansion to the model.
  task automatic push(input int cnt, input int dat, input bit last, input bit keep);
    rle_word_t w;
    bit acc = 0;
    bit ena_s = 0;
    int n;
    w.cnt = cnt[P_CW-1:0];
    w.dat = dat[P_DW-1:0];
    sti_tdata  = w;
    sti_tlast  = last;
    sti_tkeep  = keep;
    sti_tvalid = 1'b1;
    for (int i = 0; i < 1000 && !acc; i++) begin
      @(negedge clk);
      if (sti_tready === 1'b1) begin
        acc   = 1;
        ena_s = cfg_ena;
      end
      tick();
    end
    sti_tvalid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $error("FAIL push_timeout observed=not_accepted expected=accepted");
    end else begin
      n = ena_s ? cnt + 1 : 1;
      for (int k = 0; k < n; k++)
        exp_q.push_back({last && (k == n - 1), keep, w.dat});
      exp_pushed += n;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
  endtask

  function automatic logic [P_SW-1:0] exp_sts();
`ifdef RLE_DEC_CNT_EN
    return P_SW'(exp_pushed);
`else
    return '0;
`endif
  endfunction

  // ---------------- stimulus ----------------
  int b0;
  initial begin
    rst = 1'b1; ctl_rst = 1'b0; cfg_ena = 1'b1;
    sti_tdata = '0; sti_tkeep = 1'b0; sti_tlast = 1'b0; sti_tvalid = 1'b0;
    sto_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_tvalid", sto_tvalid, 0);
    chk("rst_tdata",  sto_tdata, 0);
    chk("rst_tlast",  sto_tlast, 0);
    chk("rst_tkeep",  sto_tkeep, 0);
    chk("rst_sts",    sts_smp, 0);
    chk("rst_tready", sti_tready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Single run of four samples, checking latency and input ready.
    push(3, 8'hA5, 1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("latency_valid", sto_tvalid, 1);
      chk("run_sti_tready", sti_tready, (i == 3) ? 1 : 0);
      tick();
    end
    drain();
    chk("single_sts", sts_smp, exp_sts());

    // Back-to-back words must come out with no gaps.
    first_cyc = -1;
    b0 = n_beats;
    push(0, 8'h11, 0, 1);
    push(1, 8'h22, 0, 1);
    push(0, 8'h33, 1, 1);
    drain();
    chk("b2b_beats", n_beats - b0, 4);
    chk("b2b_span", last_cyc - first_cyc + 1, 4);

    // Backpressure: ready pattern 1,0,0,1,1 over a three-sample run.
    b0 = n_beats;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    push(2, 8'h5A, 1, 1);
    drain();
    chk("bp_beats", n_beats - b0, 3);

    // Longest run.
    b0 = n_beats;
    push(255, 8'hFF, 1, 1);
    drain();
    chk("max_beats", n_beats - b0, 256);
    chk("max_sts", sts_smp, exp_sts());

    // Pass-through ignores the count field.
    b0 = n_beats;
    cfg_ena = 1'b0;
    push(7, 8'h01, 0, 1);
    push(200, 8'h02, 1, 0);
    drain();
    chk("pass_beats", n_beats - b0, 2);
    cfg_ena = 1'b1;

    // Soft reset after two samples of a ten-sample run.
    b0 = n_beats;
    push(9, 8'hC3, 1, 1);
    tick();
    ctl_rst = 1'b1;
    tick();
    ctl_rst = 1'b0;
    exp_q.delete();
    exp_pushed = 0;
    @(negedge clk);
    chk("srst_beats", n_beats - b0, 2);
    chk("srst_tvalid", sto_tvalid, 0);
    chk("srst_tready", sti_tready, 1);
    chk("srst_sts", sts_smp, 0);
    tick();
    b0 = n_beats;
    push(0, 8'h44, 1, 1);
    drain();
    chk("srst_new_beats", n_beats - b0, 1);
    chk("srst_new_sts", sts_smp, exp_sts());

    // Random words, random gaps, random ready and cfg_ena toggling.
    rdy_rand = 1;
    for (int i = 0; i < 60; i++) begin
      int c;
      c = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
      push(c, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    rdy_rand = 0;
    cfg_ena  = 1'b1;
    tick();
    chk("rand_sts", sts_smp, exp_sts());
    chk("rand_idle_valid", sto_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rle_dec.md
Name: rle_dec

Overview:
- Run-length decoder for the logic analyzer capture path.
- Takes the 16-bit {count, data} stream produced by the LA RLE encoder and expands it back to one 8-bit sample per output beat.
- Used for DMA replay loopback, the pattern generator, and self-test of the encoder path.
- Single AXI4-stream lane in, single lane out, full throughput: one sample per clock while the output is ready.

Parameters:
- DW, 8: sample data width.
- CW, 8: run-length counter width.
- SW, 32: expanded-sample status counter width (only used with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ctl_rst  in  1  soft reset pulse, synchronous, same effect as rst.
- cfg_ena  in  1  1: decode runs; 0: pass-through, count field ignored.
- sti_tdata  in  CW+DW  input word, [CW+DW-1:DW]=count, [DW-1:0]=data.
- sti_tkeep  in  1  lane keep, forwarded.
- sti_tlast  in  1  packet end.
- sti_tvalid  in  1  input valid.
- sti_tready  out  1  input ready.
- sto_tdata  out  DW  expanded sample.
- sto_tkeep  out  1  lane keep.
- sto_tlast  out  1  packet end, on last sample of the last word only.
- sto_tvalid  out  1  output valid.
- sto_tready  in  1  output ready.
- sts_smp  out  SW  total expanded samples accepted downstream.

Behaviour:
- Run length = count+1. count=0 gives 1 sample; count=2^CW-1 gives 2^CW samples.
- Holding register: dat, kep, lst, rem (CW bits), plus a busy flag.
- States:
  - IDLE (busy=0): sti_tready=1. When sti_tvalid=1: load the word; rem = cfg_ena ? count : 0; go to RUN.
  - RUN (busy=1): sto_tvalid=1, sto_tdata=dat.
    - On sto_tready with rem!=0: rem decrements.
    - On sto_tready with rem==0: run is finished.
- Back-to-back loading: sti_tready = ~busy | (rem==0 & sto_tready). If the run finishes and sti_tvalid=1 in the same cycle, the next word loads and the state stays RUN. There is no bubble between runs.
- Latency: 1 cycle from input acceptance to the first output beat (registered output).
- sto_tlast = lst & (rem==0). Intermediate samples of a run carry tlast=0.
- sto_tkeep = kep while busy.
- Output stability: while sto_tvalid=1 and sto_tready=0, sto_tdata, sto_tlast and sto_tkeep are held constant. The AXI stability rule holds.
- cfg_ena is sampled only at word load. Changing it mid-run does not affect the current run.
- rst or ctl_rst (either, any cycle, including mid-run): busy=0, rem=0, dat=0, lst=0, kep=0, sts_smp=0. The partially emitted run is discarded. sti_tready=1 the following cycle.
- Reset values: sto_tvalid=0, sto_tdata=0, sto_tlast=0, sto_tkeep=0, sts_smp=0, sti_tready=1.
- rem is unsigned CW-bit and never wraps; decrement only occurs when rem!=0.

Optional Feature:
- Macro: RLE_DEC_CNT_EN.
- Defined: sts_smp increments by 1 on every sto_tvalid & sto_tready beat and wraps modulo 2^SW.
- Not defined: sts_smp is tied to 0 and the counter logic is removed.

Decomposition:
- Package rle_pkg holds:
  - the word layout typedef: packed struct {logic [CW-1:0] cnt; logic [DW-1:0] dat;}, shared with the encoder;
  - localparam defaults DW=8, CW=8.
- No sub-module; the FSM, holding register and optional counter are inline.

Test Plan:
- Single run, count=3, data=0xA5, tready=1 -> outputs A5,A5,A5,A5 on 4 consecutive cycles; sti_tready low for cycles 1..3.
- Back-to-back words {0,0x11},{1,0x22},{0,0x33}, tlast on the last word -> 11,22,22,33 with no gaps; tlast only on 33.
- Backpressure: run count=2, data=0x5A with sto_tready toggling 1,0,0,1,1 -> exactly 3 beats of 0x5A; data and tlast stable while stalled.
- Max run count=255, data=0xFF -> 256 beats; with RLE_DEC_CNT_EN defined, sts_smp=256.
- cfg_ena=0 with words {7,0x01},{200,0x02} -> exactly 01,02.
- ctl_rst asserted after 2 of 10 beats of run {9,0xC3} -> sto_tvalid=0 next cycle, sts_smp=0; a new word {0,0x44} then yields a single 0x44.
